// File: rtl/div_seq_ctrl.sv
// Multi-cycle RV32M divide/remainder sequencer: radix-2 restoring division,
// one quotient bit per clock, valid/ready request and response interfaces.
module div_seq_ctrl #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [BIT_WIDTH-1:0] req_dividend,
  input  logic [BIT_WIDTH-1:0] req_divisor,
  input  logic                 flush,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BIT_WIDTH-1:0] rsp_result,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int CW = (BIT_WIDTH > 2) ? $clog2(BIT_WIDTH) : 1;
  localparam logic [BIT_WIDTH-1:0] MIN_NEG = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  // Handshakes: a request transfers on a rising edge where req_valid and
  // req_ready are both high; a response transfers where rsp_valid and
  // rsp_ready are both high. Once raised, rsp_valid and rsp_result hold until
  // the transfer, flush or reset.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state_q;
  logic [1:0]           op_q;
  logic [BIT_WIDTH-1:0] a_q;
  logic [BIT_WIDTH-1:0] b_q;
  logic [BIT_WIDTH-1:0] quo_q;
  logic [BIT_WIDTH-1:0] rem_q;
  logic [BIT_WIDTH-1:0] dvsr_q;
  logic [CW-1:0]        cnt_q;
  logic                 neg_q_q;
  logic                 neg_r_q;
  logic [BIT_WIDTH-1:0] res_q;
  logic                 rsp_valid_q;

  logic                 is_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic [BIT_WIDTH-1:0] abs_a;
  logic [BIT_WIDTH-1:0] abs_b;
  logic                 div_zero;
  logic                 ovf;
  logic [BIT_WIDTH-1:0] special_res;
  logic [BIT_WIDTH:0]   rem_shift;
  logic [BIT_WIDTH:0]   diff;
  logic                 ge;
  logic [BIT_WIDTH-1:0] rem_step_d;
  logic [BIT_WIDTH-1:0] quo_step_d;
  logic [BIT_WIDTH-1:0] quo_fix;
  logic [BIT_WIDTH-1:0] rem_fix;

  always_comb begin
    is_signed   = ~op_q[0];
    a_neg       = is_signed & a_q[BIT_WIDTH-1];
    b_neg       = is_signed & b_q[BIT_WIDTH-1];
    abs_a       = a_neg ? (~a_q + 1'b1) : a_q;
    abs_b       = b_neg ? (~b_q + 1'b1) : b_q;
    div_zero    = (b_q == '0);
    ovf         = is_signed && (a_q == MIN_NEG) && (b_q == '1);
    special_res = op_q[1] ? (div_zero ? a_q : '0) : (div_zero ? '1 : MIN_NEG);
    // The partial remainder always stays below the divisor, so the borrow out
    // of the (BIT_WIDTH+1)-bit subtract is exactly "shifted remainder < divisor".
    rem_shift   = {rem_q, quo_q[BIT_WIDTH-1]};
    diff        = rem_shift - {1'b0, dvsr_q};
    ge          = ~diff[BIT_WIDTH];
    rem_step_d  = ge ? diff[BIT_WIDTH-1:0] : rem_shift[BIT_WIDTH-1:0];
    quo_step_d  = {quo_q[BIT_WIDTH-2:0], ge};
    quo_fix     = neg_q_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix     = neg_r_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            a_q     <= req_dividend;
            b_q     <= req_divisor;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          neg_q_q <= a_neg ^ b_neg;
          neg_r_q <= a_neg;
          quo_q   <= abs_a;
          dvsr_q  <= abs_b;
          rem_q   <= '0;
          cnt_q   <= '0;
          if (div_zero || ovf) begin
            res_q   <= special_res;
            state_q <= S_DONE;
          end else begin
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          rem_q <= rem_step_d;
          quo_q <= quo_step_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(BIT_WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          res_q   <= op_q[1] ? rem_fix : quo_fix;
          state_q <= S_DONE;
        end
        S_DONE: begin
          // rsp_valid is registered off DONE, so it rises one edge after entry.
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = res_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: driver tasks issue operations and push the
// hand-computed result; an independent monitor pops and compares on each response.
module tb_div_seq_ctrl;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_dividend;
  logic [W-1:0] req_divisor;
  logic         flush;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         busy;
  logic [2:0]   dbg_state;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];

  div_seq_ctrl #(.BIT_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .flush        (flush),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e;
    string        nm;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got 0x%08h expected no response", rsp_result);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, rsp_result, e);
        end
      end
    end
  end

  // driver tasks; all start and end 1 time unit after a rising edge
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input string name, input bit expect_rsp);
    int guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, " req_ready"}, W'(req_ready), W'(1));
    req_valid    = 1'b1;
    req_op       = op;
    req_dividend = a;
    req_divisor  = b;
    if (expect_rsp) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_op       = 2'($urandom_range(0, 3));
    req_dividend = $urandom();
    req_divisor  = $urandom();
  endtask

  task automatic wait_rsp(input int exp_lat, input string name);
    int cnt = 0;
    while (!rsp_valid && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({name, " latency"}, W'(cnt), W'(exp_lat));
    if (rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp, input int lat, input string name);
    issue(op, a, b, exp, name, 1'b1);
    wait_rsp(lat, name);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " busy"},      W'(busy),      W'(0));
    check({name, " rsp_valid"}, W'(rsp_valid), W'(0));
    check({name, " req_ready"}, W'(req_ready), W'(1));
    check({name, " state"},     W'(dbg_state), W'(0));
  endtask

  task automatic quiet_window(input string name);
    int seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check({name, " no_rsp"}, W'(seen), W'(0));
  endtask

  initial begin
    int           guard;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_op       = 2'b00;
    req_dividend = '0;
    req_divisor  = '0;
    flush        = 1'b0;
    rsp_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset rsp_result", rsp_result, 32'h0);
    rst = 1'b0;

    // normal path
    run(2'b00, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 35, "div_m7_2");
    run(2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 35, "rem_m7_2");
    run(2'b01, 32'hFFFF_FFFF, 32'd2,        32'h7FFF_FFFF, 35, "divu_max_2");
    run(2'b11, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 35, "remu_max_2");
    run(2'b11, 32'd100,       32'd7,        32'd2,         35, "remu_100_7");
    // special cases
    run(2'b00, 32'd5,         32'd0,        32'hFFFF_FFFF,  2, "div_5_0");
    run(2'b10, 32'd5,         32'd0,        32'd5,          2, "rem_5_0");
    run(2'b01, 32'd0,         32'd0,        32'hFFFF_FFFF,  2, "divu_0_0");
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf");
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2, "rem_ovf");
    run(2'b00, 32'h8000_0000, 32'd1,        32'h8000_0000, 35, "div_min_1");

    // flush in IDLE blocks an accept
    req_valid = 1'b1;
    flush     = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    check_idle_outputs("idle_flush");

    // backpressure, then back-to-back request
    rsp_ready = 1'b0;
    issue(2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, "bp_div", 1'b1);
    wait_rsp(35, "bp_div");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp rsp_valid",  W'(rsp_valid), W'(1));
      check("bp rsp_result", rsp_result,    32'hFFFF_FFF2);
      check("bp req_ready",  W'(req_ready), W'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release req_ready", W'(req_ready), W'(1));
    check("bp release rsp_valid", W'(rsp_valid), W'(0));
    run(2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 35, "b2b_rem");

    // flush in ITER at counter 10
    issue(2'b01, 32'd1000, 32'd10, 32'd0, "flush_op", 1'b0);
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_idle_outputs("flush_iter");
    quiet_window("flush_iter");
    run(2'b01, 32'd1000, 32'd10, 32'd100, 35, "divu_after_flush");

    // reset in ITER at counter 10
    issue(2'b01, 32'd1000, 32'd10, 32'd0, "rst_op", 1'b0);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("rst_iter");
    check("rst_iter rsp_result", rsp_result, 32'h0);
    quiet_window("rst_iter");
    run(2'b01, 32'd1000, 32'd10, 32'd100, 35, "divu_after_rst");

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("pending_expected", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
